adder_7b_acc_ctrl: RTL and testbench

ADDER_7B_ACC_CTRL -- requirements
Module: adder_7b_acc_ctrl

---
 rtl/adder_7b_acc_ctrl.sv | 134 +++++++++++++
 tb/tb_adder_7b_acc_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_7b_acc_ctrl.sv
// ---------------------------------------------------------------------------
// adder_7b_acc_ctrl
//
// Controller that sums N_TERMS signed 7-bit terms into one result. The
// addition itself is done by an external combinational 7-bit adder. This
// block supplies the adder operands, saturates the adder result, and
// handles the valid/ready handshakes on the input and output sides.
//
// Ports
//   clk        : single clock; all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   clear      : synchronous abort of the accumulation in progress
//   in_valid   : a term is offered on in_data
//   in_ready   : a term can be accepted this cycle
//   in_data    : signed 7-bit term
//   out_valid  : the accumulated result is available
//   out_ready  : the consumer takes the result this cycle
//   out_sum    : signed 7-bit result (zero while no result is held)
//   out_sat    : saturation happened while building this result
//   add_a      : adder operand A (the accumulator register)
//   add_b      : adder operand B (in_data)
//   add_cin    : adder carry-in (tied to zero)
//   add_s      : adder sum (combinational)
//   add_ovf    : adder signed-overflow flag (combinational)
// ---------------------------------------------------------------------------
module adder_7b_acc_ctrl #(
  parameter int N_TERMS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] out_sum,
  output logic       out_sat,
  output logic [6:0] add_a,
  output logic [6:0] add_b,
  output logic       add_cin,
  input  logic [6:0] add_s,
  input  logic       add_ovf
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic             accept;
  logic [CNT_W-1:0] cnt_inc;
  logic [6:0]       sat_sum;

  // in_ready depends only on state, so there is no path from out_ready.
  assign in_ready  = (state_q != ST_DONE);
  assign accept    = in_valid && in_ready;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  // On signed overflow both operands had the same sign, so the sign of the
  // accumulator tells which rail the true sum crossed.
  assign sat_sum   = add_ovf ? (acc_q[6] ? 7'b1000000 : 7'b0111111) : add_s;

  assign add_a     = acc_q;
  assign add_b     = in_data;
  assign add_cin   = 1'b0;

  assign out_valid = (state_q == ST_DONE);
  assign out_sum   = out_valid ? acc_q : 7'd0;
  assign out_sat   = out_valid && sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= 7'd0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // clear outranks both a concurrent accept and a concurrent out_ready.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (clear) begin
      state_d = ST_IDLE;
      acc_d   = 7'd0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACC: begin
          if (accept) begin
            acc_d   = sat_sum;
            cnt_d   = cnt_inc;
            sat_d   = sat_q || add_ovf;
            state_d = (cnt_inc == LAST_CNT) ? ST_DONE : ST_ACC;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
            acc_d   = 7'd0;
            cnt_d   = '0;
            sat_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          acc_d   = 7'd0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_7b_acc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adder_7b_acc_ctrl
//
// Bench for adder_7b_acc_ctrl. Three instances (N_TERMS = 4, 2, 1) share
// the input stimulus. Each instance has its own behavioural model of the
// external 7-bit adder. A reference model with saturating integer
// arithmetic predicts the outputs of whichever instance is selected.
// ---------------------------------------------------------------------------
module tb_adder_7b_acc_ctrl;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [6:0] in_data;
  logic       out_ready;

  logic       in_ready_4, out_valid_4, out_sat_4, add_cin_4, add_ovf_4;
  logic [6:0] out_sum_4, add_a_4, add_b_4, add_s_4;
  logic       in_ready_2, out_valid_2, out_sat_2, add_cin_2, add_ovf_2;
  logic [6:0] out_sum_2, add_a_2, add_b_2, add_s_2;
  logic       in_ready_1, out_valid_1, out_sat_1, add_cin_1, add_ovf_1;
  logic [6:0] out_sum_1, add_a_1, add_b_1, add_s_1;

  // Observed outputs of the selected instance
  int         sel;
  logic       o_in_ready, o_out_valid, o_out_sat, o_add_cin;
  logic [6:0] o_out_sum, o_add_a, o_add_b;

  // Reference model state
  int n_terms;
  int m_acc;
  int m_cnt;
  bit m_done;
  bit m_sat;

  int n_cmp;
  int n_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External adders: 7-bit wrap-around sum plus signed overflow
  assign add_s_4   = add_a_4 + add_b_4;
  assign add_ovf_4 = (add_a_4[6] == add_b_4[6]) && (add_s_4[6] != add_a_4[6]);
  assign add_s_2   = add_a_2 + add_b_2;
  assign add_ovf_2 = (add_a_2[6] == add_b_2[6]) && (add_s_2[6] != add_a_2[6]);
  assign add_s_1   = add_a_1 + add_b_1;
  assign add_ovf_1 = (add_a_1[6] == add_b_1[6]) && (add_s_1[6] != add_a_1[6]);

  adder_7b_acc_ctrl #(.N_TERMS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready_4), .in_data(in_data), .out_valid(out_valid_4),
    .out_ready(out_ready), .out_sum(out_sum_4), .out_sat(out_sat_4),
    .add_a(add_a_4), .add_b(add_b_4), .add_cin(add_cin_4),
    .add_s(add_s_4), .add_ovf(add_ovf_4)
  );

  adder_7b_acc_ctrl #(.N_TERMS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready_2), .in_data(in_data), .out_valid(out_valid_2),
    .out_ready(out_ready), .out_sum(out_sum_2), .out_sat(out_sat_2),
    .add_a(add_a_2), .add_b(add_b_2), .add_cin(add_cin_2),
    .add_s(add_s_2), .add_ovf(add_ovf_2)
  );

  adder_7b_acc_ctrl #(.N_TERMS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready_1), .in_data(in_data), .out_valid(out_valid_1),
    .out_ready(out_ready), .out_sum(out_sum_1), .out_sat(out_sat_1),
    .add_a(add_a_1), .add_b(add_b_1), .add_cin(add_cin_1),
    .add_s(add_s_1), .add_ovf(add_ovf_1)
  );

  always_comb begin
    o_in_ready  = in_ready_4;
    o_out_valid = out_valid_4;
    o_out_sum   = out_sum_4;
    o_out_sat   = out_sat_4;
    o_add_a     = add_a_4;
    o_add_b     = add_b_4;
    o_add_cin   = add_cin_4;
    case (sel)
      2: begin
        o_in_ready  = in_ready_2;
        o_out_valid = out_valid_2;
        o_out_sum   = out_sum_2;
        o_out_sat   = out_sat_2;
        o_add_a     = add_a_2;
        o_add_b     = add_b_2;
        o_add_cin   = add_cin_2;
      end
      1: begin
        o_in_ready  = in_ready_1;
        o_out_valid = out_valid_1;
        o_out_sum   = out_sum_1;
        o_out_sat   = out_sat_1;
        o_add_a     = add_a_1;
        o_add_b     = add_b_1;
        o_add_cin   = add_cin_1;
      end
      default: ;
    endcase
  end

  task checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Compare every observable output of the selected instance with the model
  task checkOutput();
    checkVal("in_ready",  {31'd0, o_in_ready},  m_done ? 0 : 1);
    checkVal("out_valid", {31'd0, o_out_valid}, m_done ? 1 : 0);
    checkVal("out_sum",   32'($signed(o_out_sum)), m_done ? m_acc : 0);
    checkVal("out_sat",   {31'd0, o_out_sat},   (m_done && m_sat) ? 1 : 0);
    checkVal("add_a",     32'($signed(o_add_a)), m_acc);
    checkVal("add_b",     32'($signed(o_add_b)), 32'($signed(in_data)));
    checkVal("add_cin",   {31'd0, o_add_cin},   0);
  endtask

  task modelClear();
    m_acc  = 0;
    m_cnt  = 0;
    m_done = 1'b0;
    m_sat  = 1'b0;
  endtask

  // Drive one cycle of inputs, predict the effect of the next edge, then
  // check the outputs just after that edge.
  task applyStimulus(input bit v, input int d, input bit c, input bit r);
    int t;
    in_valid  = v;
    in_data   = d[6:0];
    clear     = c;
    out_ready = r;
    if (c) begin
      modelClear();
    end else if (m_done) begin
      if (r) modelClear();
    end else if (v) begin
      t = m_acc + d;
      if (t > 63) begin
        t = 63;
        m_sat = 1'b1;
      end else if (t < -64) begin
        t = -64;
        m_sat = 1'b1;
      end
      m_acc = t;
      m_cnt++;
      if (m_cnt == n_terms) m_done = 1'b1;
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Asynchronous reset pulse taken between clock edges
  task doReset();
    in_valid  = 1'b0;
    in_data   = 7'd0;
    clear     = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelClear();
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task randomRun(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    int'($urandom_range(0, 127)) - 64,
                    $urandom_range(0, 31) == 0,
                    $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    sel       = 4;
    n_terms   = 4;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 7'd0;
    out_ready = 1'b0;
    modelClear();
    #2;
    $display("[TB] reset state, N_TERMS=4");
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back terms without saturation
    applyStimulus(1, 10, 0, 0);
    applyStimulus(1, 20, 0, 0);
    applyStimulus(1, -10, 0, 0);
    applyStimulus(1, -15, 0, 0);
    checkVal("plain_sum", 32'($signed(o_out_sum)), 5);
    checkVal("plain_sat", {31'd0, o_out_sat}, 0);
    applyStimulus(0, 0, 0, 1);

    // Positive overflow on the last term
    applyStimulus(1, 10, 0, 0);
    applyStimulus(1, 20, 0, 0);
    applyStimulus(1, -10, 0, 0);
    applyStimulus(1, 50, 0, 0);
    checkVal("pos_sat_sum", 32'($signed(o_out_sum)), 63);
    checkVal("pos_sat_flag", {31'd0, o_out_sat}, 1);
    applyStimulus(0, 0, 0, 1);

    // Negative overflow early, sticky flag
    applyStimulus(1, -32, 0, 0);
    applyStimulus(1, -51, 0, 0);
    checkVal("neg_sat_acc", 32'($signed(o_add_a)), -64);
    applyStimulus(1, 43, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkVal("neg_sat_sum", 32'($signed(o_out_sum)), -21);
    checkVal("neg_sat_flag", {31'd0, o_out_sat}, 1);
    applyStimulus(0, 0, 0, 1);

    // clear beats a concurrent term
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 2, 0, 0);
    applyStimulus(1, 7, 1, 0);
    checkVal("clear_acc", 32'($signed(o_add_a)), 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 2, 0, 0);
    applyStimulus(1, 3, 0, 0);
    applyStimulus(1, 4, 0, 0);
    checkVal("after_clear_sum", 32'($signed(o_out_sum)), 10);
    applyStimulus(0, 0, 0, 1);

    // Reset in the middle of an accumulation
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 2, 0, 0);
    applyStimulus(1, 3, 0, 0);
    doReset();
    checkVal("async_rst_acc", 32'($signed(o_add_a)), 0);
    applyStimulus(1, 5, 0, 0);
    applyStimulus(1, 5, 0, 0);
    applyStimulus(1, 5, 0, 0);
    applyStimulus(1, 5, 0, 0);
    checkVal("after_rst_sum", 32'($signed(o_out_sum)), 20);
    checkVal("after_rst_sat", {31'd0, o_out_sat}, 0);
    applyStimulus(0, 0, 0, 1);

    $display("[TB] random traffic, N_TERMS=4");
    randomRun(300);

    // N_TERMS=2: result held while the consumer stalls
    sel     = 2;
    n_terms = 2;
    doReset();
    applyStimulus(1, 40, 0, 0);
    applyStimulus(1, -13, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 9, 0, 0);
      checkVal("stall_sum", 32'($signed(o_out_sum)), 27);
      checkVal("stall_ready", {31'd0, o_in_ready}, 0);
    end
    applyStimulus(1, 9, 0, 1);
    checkVal("release_acc", 32'($signed(o_add_a)), 0);
    checkVal("release_valid", {31'd0, o_out_valid}, 0);
    $display("[TB] random traffic, N_TERMS=2");
    randomRun(150);

    // N_TERMS=1: a single accept produces the result
    sel     = 1;
    n_terms = 1;
    doReset();
    applyStimulus(1, -7, 0, 0);
    checkVal("single_valid", {31'd0, o_out_valid}, 1);
    checkVal("single_sum", 32'($signed(o_out_sum)), -7);
    applyStimulus(1, 3, 0, 1);
    $display("[TB] random traffic, N_TERMS=1");
    randomRun(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
